fetch_stage: RTL and testbench

- Instruction fetch stage that generates the PC, talks to instruction memory over a request/grant/response handshake, and drives the IF/ID pipeline register consumed by decode and the processor control logic.
- Handles decode back-pressure (stall) and branch redirects from the execute-side branch logic.
- Keeps at most one fetch outstanding, with a one-entry skid buffer so no returned instruction is lost.

---
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_stage.sv | 195 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory request/grant/response bundle          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fetch_stage_if #(
    parameter int unsigned WIDTH = 64
);
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage : PC generation, single-outstanding imem fetch, IF/ID register |
// | Optional perf counters enabled by macro FETCH_PERF_CNT_EN                  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_stage #(
    parameter int unsigned      WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fetch_stage_if.master     imem,
    input  wire logic         stall,
    input  wire logic         redirect,
    input  wire logic [WIDTH-1:0] redirect_pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [WIDTH-1:0]  id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SKID = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic             req_q, req_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [WIDTH-1:0] id_pc_q, id_pc_d;
    logic [31:0]      skid_instr_q, skid_instr_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;

    logic             id_load;
    logic [31:0]      load_instr;
    logic [WIDTH-1:0] load_pc;
    logic             id_free;

    assign id_free = !id_valid_q || !stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_load      = 1'b0;
        load_instr   = '0;
        load_pc      = '0;

        if (redirect) begin
            // Redirect beats stall and any same-cycle response; a granted
            // but unreturned fetch must still be drained through DROP.
            pc_d         = redirect_pc & ~WIDTH'(3);
            id_valid_d   = 1'b0;
            id_instr_d   = '0;
            id_pc_d      = '0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            case (state_q)
                S_REQ:   state_d = imem.gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem.rvalid ? S_REQ  : S_DROP;
                S_DROP:  state_d = imem.rvalid ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem.gnt) begin
                        fetch_addr_d = pc_q;
                        pc_d         = pc_q + WIDTH'(4);
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (id_free) begin
                            id_load    = 1'b1;
                            load_instr = imem.rdata;
                            load_pc    = fetch_addr_q;
                            state_d    = S_REQ;
                        end else begin
                            skid_instr_d = imem.rdata;
                            skid_pc_d    = fetch_addr_q;
                            state_d      = S_SKID;
                        end
                    end
                end
                S_SKID: begin
                    if (!stall) begin
                        id_load    = 1'b1;
                        load_instr = skid_instr_q;
                        load_pc    = skid_pc_q;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (id_load) begin
                id_valid_d = 1'b1;
                id_instr_d = load_instr;
                id_pc_d    = load_pc;
            end else if (!stall) begin
                id_valid_d = 1'b0;
                id_instr_d = '0;
                id_pc_d    = '0;
            end
        end

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= '0;
            req_q        <= 1'b0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            req_q        <= req_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'b0, (id_load && (perf_fetched_q != '1))};
        perf_stall_d   = perf_stall_q + {31'b0, (stall && id_valid_q && (perf_stall_q != '1))};
        perf_flush_d   = perf_flush_q + {31'b0, (redirect && (perf_flush_q != '1))};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage : directed + randomized bench with a queue-based fetch model|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;
    localparam int unsigned WIDTH    = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    fetch_stage_if #(.WIDTH(WIDTH)) imem_if ();

    fetch_stage #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_if),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        logic [31:0] lo, hi;
        lo = a[31:0];
        hi = a[63:32];
        return (lo * 32'h9E37_79B1) ^ hi ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a list of fetches in flight (stale once redirected) and a list
    // of returned instructions waiting for decode to accept them.
    typedef struct { logic [63:0] addr; bit stale; } fetch_t;
    typedef struct { logic [31:0] instr; logic [63:0] pc; } entry_t;
    typedef struct { logic [63:0] addr; int cnt; } resp_t;

    fetch_t      m_out[$];
    entry_t      m_hold[$];
    resp_t       mem_q[$];
    bit          m_req, m_idv;
    logic [31:0] m_instr;
    logic [63:0] m_idpc, m_pc;
    int          mem_delay = 1;
    logic        s_req;
    logic [63:0] s_addr;
    bit          cmp_en = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] m_fetched, m_stall, m_flush;
`endif

    function automatic void model_reset();
        m_out.delete();
        m_hold.delete();
        m_req   = 1'b0;
        m_idv   = 1'b0;
        m_instr = '0;
        m_idpc  = '0;
        m_pc    = RESET_PC;
`ifdef FETCH_PERF_CNT_EN
        m_fetched = '0;
        m_stall   = '0;
        m_flush   = '0;
`endif
    endfunction

    function automatic void model_step();
        fetch_t      o;
        entry_t      e;
        bit          load;
        logic [31:0] li;
        logic [63:0] lp;
        load = 1'b0;
        li   = '0;
        lp   = '0;
`ifdef FETCH_PERF_CNT_EN
        if (stall && m_idv && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
        if (redirect) begin
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            if (m_req && imem_if.gnt) m_out.push_back('{m_pc, 1'b1});
            if (imem_if.rvalid && m_out.size() > 0) void'(m_out.pop_front());
            m_hold.delete();
            m_idv   = 1'b0;
            m_instr = '0;
            m_idpc  = '0;
            m_pc    = redirect_pc & ~64'h3;
        end else begin
            if (m_hold.size() > 0) begin
                if (!stall) begin
                    e    = m_hold.pop_front();
                    load = 1'b1;
                    li   = e.instr;
                    lp   = e.pc;
                end
            end else if (imem_if.rvalid && m_out.size() > 0) begin
                o = m_out.pop_front();
                if (!o.stale) begin
                    if (!m_idv || !stall) begin
                        load = 1'b1;
                        li   = instr_of(o.addr);
                        lp   = o.addr;
                    end else begin
                        m_hold.push_back('{instr_of(o.addr), o.addr});
                    end
                end
            end
            if (load) begin
                m_idv   = 1'b1;
                m_instr = li;
                m_idpc  = lp;
`ifdef FETCH_PERF_CNT_EN
                if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
`endif
            end else if (!stall) begin
                m_idv   = 1'b0;
                m_instr = '0;
                m_idpc  = '0;
            end
            if (m_req && imem_if.gnt) begin
                m_out.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 64'd4;
            end
        end
        m_req = (m_out.size() == 0) && (m_hold.size() == 0);
    endfunction

    // Advance one clock; model and memory see the inputs that were held
    // across the edge, then the memory response for the next cycle is set.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
            mem_q.delete();
        end else begin
            model_step();
            if (imem_if.rvalid) void'(mem_q.pop_front());
            foreach (mem_q[i]) if (mem_q[i].cnt > 0) mem_q[i].cnt--;
            if (s_req && imem_if.gnt) mem_q.push_back('{s_addr, mem_delay - 1});
        end
        imem_if.rvalid = (mem_q.size() > 0) && (mem_q[0].cnt == 0);
        imem_if.rdata  = imem_if.rvalid ? instr_of(mem_q[0].addr) : 32'($urandom);
    endtask

    always @(negedge clk) begin
        s_req  = imem_if.req;
        s_addr = imem_if.addr;
        if (cmp_en) begin
            chk("imem_req", 64'(imem_if.req), 64'(m_req));
            if (m_req) chk("imem_addr", imem_if.addr, m_pc);
            chk("id_valid", 64'(id_valid), 64'(m_idv));
            chk("id_instr", 64'(id_instr), 64'(m_instr));
            if (m_idv) chk("id_pc", id_pc, m_idpc);
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
            chk("perf_stall", 64'(perf_stall), 64'(m_stall));
            chk("perf_flush", 64'(perf_flush), 64'(m_flush));
`endif
        end
    end

    task automatic chk_id(input string name, input logic v, input logic [63:0] pc);
        chk({name, "_valid"}, 64'(id_valid), 64'(v));
        if (v) begin
            chk({name, "_pc"}, id_pc, pc);
            chk({name, "_instr"}, 64'(id_instr), 64'(instr_of(pc)));
        end
    endtask

    initial begin
        imem_if.gnt    = 1'b0;
        imem_if.rvalid = 1'b0;
        imem_if.rdata  = '0;
        model_reset();
        cmp_en = 1'b1;
        repeat (2) tick();
        chk("rst_req", 64'(imem_if.req), 64'h0);
        chk("rst_addr", imem_if.addr, RESET_PC);
        chk("rst_id_valid", 64'(id_valid), 64'h0);

        // Zero-wait streaming: one instruction every second cycle.
        reset = 1'b1;
        imem_if.gnt = 1'b1;
        mem_delay = 1;
        tick();
        chk("p1_req", 64'(imem_if.req), 64'h1);
        chk("p1_addr", imem_if.addr, 64'h0);
        repeat (2) tick();
        chk_id("s0", 1'b1, 64'h0);
        tick();
        chk("s0_bubble", 64'(id_valid), 64'h0);
        tick();
        chk_id("s4", 1'b1, 64'h4);
        repeat (2) tick();
        chk_id("s8", 1'b1, 64'h8);

        // Five cycles of stall while a response arrives into the skid.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_id("stall_hold", 1'b1, 64'h8);
            if (i >= 1) chk("stall_req", 64'(imem_if.req), 64'h0);
        end
        stall = 1'b0;
        tick();
        chk_id("skid_out", 1'b1, 64'hC);

        // Redirect during WAIT with a slow memory.
        mem_delay = 3;
        tick();
        redirect = 1'b1;
        redirect_pc = 64'h103;
        tick();
        redirect = 1'b0;
        chk("rw_valid", 64'(id_valid), 64'h0);
        chk("rw_req", 64'(imem_if.req), 64'h0);
        tick();
        chk("rw_drop_req", 64'(imem_if.req), 64'h0);
        tick();
        chk("rw_req2", 64'(imem_if.req), 64'h1);
        chk("rw_addr", imem_if.addr, 64'h100);
        chk("rw_nostale", 64'(id_valid), 64'h0);
        mem_delay = 1;
        repeat (2) tick();
        chk_id("rw_first", 1'b1, 64'h100);

        // Redirect in the same cycle as a grant.
        redirect = 1'b1;
        redirect_pc = 64'h200;
        tick();
        redirect = 1'b0;
        chk("rg_req", 64'(imem_if.req), 64'h0);
        tick();
        chk("rg_req2", 64'(imem_if.req), 64'h1);
        chk("rg_addr", imem_if.addr, 64'h200);
        chk("rg_valid", 64'(id_valid), 64'h0);
        repeat (2) tick();
        chk_id("rg_first", 1'b1, 64'h200);

        // Redirect while stalled with a full skid.
        stall = 1'b1;
        repeat (2) tick();
        chk_id("rs_hold", 1'b1, 64'h200);
        redirect = 1'b1;
        redirect_pc = 64'h300;
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("rs_valid", 64'(id_valid), 64'h0);
        chk("rs_addr", imem_if.addr, 64'h300);
        repeat (2) tick();
        chk_id("rs_first", 1'b1, 64'h300);

        // Asynchronous reset in the middle of a WAIT.
        mem_delay = 3;
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk("ar_req", 64'(imem_if.req), 64'h0);
        chk("ar_addr", imem_if.addr, RESET_PC);
        chk("ar_valid", 64'(id_valid), 64'h0);
        chk("ar_instr", 64'(id_instr), 64'h0);
        chk("ar_pc", id_pc, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("ar_perf_fetched", 64'(perf_fetched), 64'h0);
        chk("ar_perf_stall", 64'(perf_stall), 64'h0);
        chk("ar_perf_flush", 64'(perf_flush), 64'h0);
`endif
        model_reset();
        mem_q.delete();
        imem_if.rvalid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rr_req", 64'(imem_if.req), 64'h1);
        chk("rr_addr", imem_if.addr, RESET_PC);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            stall       = ($urandom % 100) < 30;
            redirect    = ($urandom % 100) < 6;
            redirect_pc = {$urandom, $urandom};
            imem_if.gnt = ($urandom % 100) < 60;
            mem_delay   = int'($urandom_range(1, 4));
            tick();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
